// File: rtl/mux2_arbiter_if.sv
// Handshake and datapath bundle between two requesters and the mux2_arbiter.
interface mux2_arbiter_if #(
    parameter int unsigned SIZE = 2
);
    logic            req0;
    logic            req1;
    logic [SIZE-1:0] d0;
    logic [SIZE-1:0] d1;
    logic            gnt0;
    logic            gnt1;
    logic [SIZE-1:0] z;
    logic            valid;
    logic            sel;

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, z, valid, sel
    );

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, z, valid, sel
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter owning a SIZE-bit 2:1 mux built from 1-bit cells.
// Define BURST_LIMIT_EN to force a handover after MAX_BURST consecutive grant cycles.
module mux2Cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux2_arbiter #(
    parameter int unsigned SIZE      = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux2_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arbStateT;

    if (MAX_BURST < 2 || MAX_BURST > 16) begin : gBadBurst
        $error("mux2_arbiter: MAX_BURST must be within 2..16");
    end

    arbStateT        state;
    arbStateT        nextState;
    logic            prio;
    logic            limitHit;
    logic            gnt0Q;
    logic            gnt1Q;
    logic            selQ;
    logic            validQ;
    logic [SIZE-1:0] zQ;
    logic [SIZE-1:0] muxOut;

`ifdef BURST_LIMIT_EN
    localparam int unsigned BCNT_W   = $clog2(MAX_BURST);
    localparam int unsigned BCNT_MAX = MAX_BURST - 1;
    logic [BCNT_W-1:0] bcnt;

    assign limitHit = (bcnt == BCNT_W'(BCNT_MAX));

    // Cleared on every grant entry, saturates while the owner keeps the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
        end else if (nextState != state) begin
            bcnt <= '0;
        end else if (state != IDLE && !limitHit) begin
            bcnt <= bcnt + BCNT_W'(1);
        end
    end
`else
    assign limitHit = 1'b0;
`endif

    // Shared datapath mux, one cell per bit, steered by the registered select.
    for (genvar i = 0; i < int'(SIZE); i++) begin : gMux
        mux2Cell uCell (
            .a (bus.d0[i]),
            .b (bus.d1[i]),
            .s (selQ),
            .y (muxOut[i])
        );
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (bus.req0 && (!bus.req1 || !prio)) nextState = G0;
                else if (bus.req1)                     nextState = G1;
            end
            G0: begin
                if (!bus.req0)                nextState = bus.req1 ? G1 : IDLE;
                else if (limitHit && bus.req1) nextState = G1;
            end
            G1: begin
                if (!bus.req1)                nextState = bus.req0 ? G0 : IDLE;
                else if (limitHit && bus.req0) nextState = G0;
            end
            default: nextState = IDLE;
        endcase
    end

    // Grants and select are decoded from the next state so they track the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            prio   <= 1'b0;
            gnt0Q  <= 1'b0;
            gnt1Q  <= 1'b0;
            selQ   <= 1'b0;
            zQ     <= '0;
            validQ <= 1'b0;
        end else begin
            state <= nextState;
            gnt0Q <= (nextState == G0);
            gnt1Q <= (nextState == G1);
            selQ  <= (nextState == G1);
            if (state != IDLE && nextState != state) begin
                prio <= (state == G0);
            end
            if (state != IDLE) begin
                zQ     <= muxOut;
                validQ <= 1'b1;
            end else begin
                validQ <= 1'b0;
            end
        end
    end

    assign bus.gnt0  = gnt0Q;
    assign bus.gnt1  = gnt1Q;
    assign bus.sel   = selQ;
    assign bus.z     = zQ;
    assign bus.valid = validQ;
endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed and randomized self-checking bench for mux2_arbiter.
module tb_mux2_arbiter;
    localparam int unsigned SIZE      = 2;
    localparam int unsigned MAX_BURST = 4;

    logic clk;
    logic rst_n;
    int   nCompared;
    int   nMismatched;

    mux2_arbiter_if #(.SIZE(SIZE)) bus ();

    mux2_arbiter #(.SIZE(SIZE), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       pg0, pg1, pr0, pr1, expG0;
        logic [1:0] pd0, pd1;
        nCompared   = 0;
        nMismatched = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d0   = '0;
        bus.d1   = '0;
        #12;
        checkEq("rst_gnt0",  8'(bus.gnt0),  8'd0);
        checkEq("rst_gnt1",  8'(bus.gnt1),  8'd0);
        checkEq("rst_sel",   8'(bus.sel),   8'd0);
        checkEq("rst_z",     8'(bus.z),     8'd0);
        checkEq("rst_valid", 8'(bus.valid), 8'd0);
        rst_n = 1'b1;

        // Reset mid-burst
        bus.req0 = 1'b1;
        bus.d0   = 2'b10;
        step();
        checkEq("mb_gnt0_e1",  8'(bus.gnt0),  8'd1);
        checkEq("mb_valid_e1", 8'(bus.valid), 8'd0);
        step();
        checkEq("mb_z_e2",     8'(bus.z),     8'd2);
        checkEq("mb_valid_e2", 8'(bus.valid), 8'd1);
        step();
        checkEq("mb_gnt0_e3",  8'(bus.gnt0),  8'd1);
        #3 rst_n = 1'b0;
        #1;
        checkEq("mb_rst_gnt0",  8'(bus.gnt0),  8'd0);
        checkEq("mb_rst_z",     8'(bus.z),     8'd0);
        checkEq("mb_rst_valid", 8'(bus.valid), 8'd0);
        bus.req0 = 1'b0;
        #1 rst_n = 1'b1;
        step();
        checkEq("mb_idle_gnt0", 8'(bus.gnt0), 8'd0);

        // Tie from reset: prio=0 so req0 wins, zero-gap handover to req1
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d0   = 2'b01;
        bus.d1   = 2'b10;
        step();
        checkEq("tie_gnt0", 8'(bus.gnt0), 8'd1);
        checkEq("tie_gnt1", 8'(bus.gnt1), 8'd0);
        bus.req0 = 1'b0;
        step();
        checkEq("ho_gnt0",  8'(bus.gnt0),  8'd0);
        checkEq("ho_gnt1",  8'(bus.gnt1),  8'd1);
        checkEq("ho_sel",   8'(bus.sel),   8'd1);
        checkEq("ho_z",     8'(bus.z),     8'd1);
        checkEq("ho_valid", 8'(bus.valid), 8'd1);
        bus.req1 = 1'b0;
        step();
        checkEq("ho_trail_gnt1",  8'(bus.gnt1),  8'd0);
        checkEq("ho_trail_z",     8'(bus.z),     8'd2);
        checkEq("ho_trail_valid", 8'(bus.valid), 8'd1);
        step();
        checkEq("idle_valid", 8'(bus.valid), 8'd0);
        checkEq("idle_zhold", 8'(bus.z),     8'd2);

        // Serve req0 alone so prio moves to 1, then a tie must go to req1
        bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        step();
        step();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        checkEq("tie2_gnt0", 8'(bus.gnt0), 8'd0);
        checkEq("tie2_gnt1", 8'(bus.gnt1), 8'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        step();

        // Single requester 1 for two cycles
        bus.req1 = 1'b1;
        bus.d1   = 2'b01;
        step();
        checkEq("sr_gnt1_e1",  8'(bus.gnt1),  8'd1);
        checkEq("sr_sel_e1",   8'(bus.sel),   8'd1);
        checkEq("sr_valid_e1", 8'(bus.valid), 8'd0);
        step();
        checkEq("sr_gnt1_e2",  8'(bus.gnt1),  8'd1);
        checkEq("sr_z_e2",     8'(bus.z),     8'd1);
        checkEq("sr_valid_e2", 8'(bus.valid), 8'd1);
        bus.req1 = 1'b0;
        bus.d1   = 2'b11;
        step();
        checkEq("sr_gnt1_e3",  8'(bus.gnt1),  8'd0);
        checkEq("sr_z_e3",     8'(bus.z),     8'd3);
        checkEq("sr_valid_e3", 8'(bus.valid), 8'd1);
        step();
        checkEq("sr_valid_e4", 8'(bus.valid), 8'd0);

        // Both held for 10 cycles; prio is 0 after the G1 exit above
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d0   = 2'b01;
        bus.d1   = 2'b10;
        pg0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
`ifdef BURST_LIMIT_EN
            expG0 = ((i / int'(MAX_BURST)) % 2) == 0;
`else
            expG0 = 1'b1;
`endif
            checkEq($sformatf("burst_gnt0_%0d", i), 8'(bus.gnt0), 8'(expG0));
            checkEq($sformatf("burst_gnt1_%0d", i), 8'(bus.gnt1), 8'(!expG0));
            if (i > 0) begin
                checkEq($sformatf("burst_valid_%0d", i), 8'(bus.valid), 8'd1);
                checkEq($sformatf("burst_z_%0d", i), 8'(bus.z), pg0 ? 8'd1 : 8'd2);
            end
            pg0 = expG0;
        end
        bus.req0 = 1'b0;
        step();
        checkEq("burst_rel_gnt1", 8'(bus.gnt1), 8'd1);
        checkEq("burst_rel_gnt0", 8'(bus.gnt0), 8'd0);
        bus.req1 = 1'b0;
        step();
        step();

        // Random traffic: exclusion, grant-only-on-request, data integrity
        for (int i = 0; i < 1000; i++) begin
            pg0 = bus.gnt0;
            pg1 = bus.gnt1;
            pr0 = 1'($urandom_range(0, 1));
            pr1 = 1'($urandom_range(0, 1));
            pd0 = 2'($urandom_range(0, 3));
            pd1 = 2'($urandom_range(0, 3));
            bus.req0 = pr0;
            bus.req1 = pr1;
            bus.d0   = pd0;
            bus.d1   = pd1;
            step();
            checkEq("rnd_mutex", 8'(bus.gnt0 & bus.gnt1), 8'd0);
            checkEq("rnd_sel",   8'(bus.sel), 8'(bus.gnt1));
            checkEq("rnd_noreq", 8'((bus.gnt0 & !pr0) | (bus.gnt1 & !pr1)), 8'd0);
            checkEq("rnd_valid", 8'(bus.valid), 8'(pg0 | pg1));
            if (pg0 | pg1) begin
                checkEq("rnd_z", 8'(bus.z), pg1 ? 8'(pd1) : 8'(pd0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
